uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmit path. It accepts a byte into a one-entry holding buffer and runs the start/data/parity/stop state machine on the baud tick. It drives the load and shift controls of the bit serializer and muxes the start bit, serializer output, parity bit and stop bit onto the TX line. It sits between the host-side byte interface and the TX pin, and supports back-to-back frames without an idle bit.

---
 rtl/uart_tx_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame sequencer for the UART transmit path. A one-entry holding buffer
// takes a byte (plus parity options) from the host. A start/data/parity/stop
// state machine, advanced only on the baud strobe, drives the load and
// shift controls of an external bit serializer. It also muxes the start bit,
// the serializer bit, the parity bit and the stop bit onto the TX line.
// Frames may run back-to-back without an idle bit between them.
//
// Ports:
//   CLK         single clock
//   RST         synchronous, active-low reset
//   TX_tick     one-cycle baud strobe; every state transition happens on it
//   P_DATA      byte to send, sampled on accept
//   DATA_VALID  host offers P_DATA
//   PAR_EN      parity enable, sampled on accept
//   PAR_TYP     parity type (0 = even, 1 = odd), sampled on accept
//   ser_data    current serializer bit (bit 0 after load, LSB first)
//   ser_done    serializer is presenting its last bit
//   READY       holding buffer empty
//   ser_load    registered one-cycle pulse: load frame byte into serializer
//   ser_shift   registered one-cycle pulse: advance serializer by one bit
//   TX_OUT      serial line, idle high
//   BUSY        frame in progress
//   TX_DONE     registered one-cycle pulse at the end of a stop bit
//   FRAME_ERR   registered one-cycle pulse: ser_done low after last data bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  READY,
  output logic                  ser_load,
  output logic                  ser_shift,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE,
  output logic                  FRAME_ERR
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit that goes on the line: even parity makes the total count of
  // ones (data + parity) even; odd type inverts it.
  function automatic logic calc_par_bit(input logic [DATA_WIDTH-1:0] data,
                                        input logic                  par_typ);
    return (^data) ^ par_typ;
  endfunction

  // Sequencer state
  state_t           state_r, state_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             start_s;

  // Registered control pulses
  logic ser_load_r, ser_load_s;
  logic ser_shift_r, ser_shift_s;
  logic tx_done_r, tx_done_s;
  logic frame_err_r, frame_err_s;

  // Holding buffer
  logic                  hold_v_r, hold_v_s;
  logic [DATA_WIDTH-1:0] hold_data_r, hold_data_s;
  logic                  hold_par_en_r, hold_par_en_s;
  logic                  hold_par_typ_r, hold_par_typ_s;

  // Per-frame parity settings, frozen for the whole frame
  logic frm_par_en_r, frm_par_en_s;
  logic frm_par_bit_r, frm_par_bit_s;

  logic tx_out_s;

  // Next-state and next-pulse logic of the frame sequencer.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    start_s     = 1'b0;
    ser_shift_s = 1'b0;
    tx_done_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (TX_tick && hold_v_r) begin
          state_s = ST_START;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (TX_tick) begin
          state_s   = ST_DATA;
          bit_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (TX_tick) begin
          if (bit_cnt_r != LAST_BIT) begin
            ser_shift_s = 1'b1;
            bit_cnt_s   = bit_cnt_r + CNT_W'(1);
          end else begin
            // Last data bit: the serializer must agree it is on its last bit.
            // A mismatch is flagged but the frame still completes.
            frame_err_s = ~ser_done;
            state_s     = frm_par_en_r ? ST_PARITY : ST_STOP;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (TX_tick) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (TX_tick) begin
          tx_done_s = 1'b1;
          if (hold_v_r) begin
            // Back-to-back: next start bit directly follows this stop bit.
            state_s = ST_START;
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        bit_cnt_s = {CNT_W{1'b0}};
      end
    endcase
    ser_load_s = start_s;
  end

  // Holding-buffer accept/free and frame-register capture.
  always_comb begin
    hold_v_s       = hold_v_r;
    hold_data_s    = hold_data_r;
    hold_par_en_s  = hold_par_en_r;
    hold_par_typ_s = hold_par_typ_r;
    frm_par_en_s   = frm_par_en_r;
    frm_par_bit_s  = frm_par_bit_r;
    if (start_s) begin
      // A frame start always sees a full buffer, so no accept can coincide.
      hold_v_s      = 1'b0;
      frm_par_en_s  = hold_par_en_r;
      frm_par_bit_s = calc_par_bit(hold_data_r, hold_par_typ_r);
    end else if (DATA_VALID && !hold_v_r) begin
      hold_v_s       = 1'b1;
      hold_data_s    = P_DATA;
      hold_par_en_s  = PAR_EN;
      hold_par_typ_s = PAR_TYP;
    end else begin
      hold_v_s = hold_v_r;
    end
  end

  // Line multiplexer: selects the bit source for the current frame section.
  always_comb begin
    tx_out_s = 1'b1;
    case (state_r)
      ST_IDLE:   tx_out_s = 1'b1;
      ST_START:  tx_out_s = 1'b0;
      ST_DATA:   tx_out_s = ser_data;
      ST_PARITY: tx_out_s = frm_par_bit_r;
      ST_STOP:   tx_out_s = 1'b1;
      default:   tx_out_s = 1'b1;
    endcase
  end

  // State register and bit counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
    end
  end

  // Registered one-cycle control and status pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ser_load_r  <= 1'b0;
      ser_shift_r <= 1'b0;
      tx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      ser_load_r  <= ser_load_s;
      ser_shift_r <= ser_shift_s;
      tx_done_r   <= tx_done_s;
      frame_err_r <= frame_err_s;
    end
  end

  // Holding buffer and frame parity registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_v_r       <= 1'b0;
      hold_data_r    <= {DATA_WIDTH{1'b0}};
      hold_par_en_r  <= 1'b0;
      hold_par_typ_r <= 1'b0;
      frm_par_en_r   <= 1'b0;
      frm_par_bit_r  <= 1'b0;
    end else begin
      hold_v_r       <= hold_v_s;
      hold_data_r    <= hold_data_s;
      hold_par_en_r  <= hold_par_en_s;
      hold_par_typ_r <= hold_par_typ_s;
      frm_par_en_r   <= frm_par_en_s;
      frm_par_bit_r  <= frm_par_bit_s;
    end
  end

  assign READY     = ~hold_v_r;
  assign BUSY      = (state_r != ST_IDLE);
  assign ser_load  = ser_load_r;
  assign ser_shift = ser_shift_r;
  assign TX_DONE   = tx_done_r;
  assign FRAME_ERR = frame_err_r;
  assign TX_OUT    = tx_out_s;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Scoreboard bench for uart_tx_ctrl. Each accepted byte pushes its expected
// line frame (start, LSB-first data, optional parity, stop) into a queue; a
// monitor collects the line bit seen on every baud tick of a frame and, on
// each TX_DONE, pops and compares the frame together with its serializer
// pulse counts and FRAME_ERR count. A behavioural serializer feeds ser_data
// and ser_done from the bytes the bench itself handed over.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          err;
  } frame_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          TX_tick = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          ser_data;
  logic          ser_done;
  logic          READY, ser_load, ser_shift, TX_OUT, BUSY, TX_DONE, FRAME_ERR;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .TX_tick(TX_tick), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .ser_data(ser_data), .ser_done(ser_done), .READY(READY),
    .ser_load(ser_load), .ser_shift(ser_shift), .TX_OUT(TX_OUT),
    .BUSY(BUSY), .TX_DONE(TX_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  frame_t        exp_q[$];
  logic [DW-1:0] ser_q[$];
  int            done_time[$];

  // Baud strobe: one CLK-wide pulse every tick_div cycles.
  int tick_div = 4;
  int tick_cnt = 0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (tick_cnt >= tick_div - 1) begin
        TX_tick  = 1'b1;
        tick_cnt = 0;
      end else begin
        TX_tick  = 1'b0;
        tick_cnt = tick_cnt + 1;
      end
    end
  end

  // Behavioural serializer: shows bit 0 after load, advances on shift.
  logic [DW-1:0] sreg = '0;
  logic [2:0]    sidx = 3'd0;
  bit            force_nodone = 1'b0;
  always @(posedge CLK) begin
    if (!RST) begin
      sreg <= '0;
      sidx <= 3'd0;
      ser_q.delete();
    end else if (ser_load) begin
      sreg <= (ser_q.size() > 0) ? ser_q.pop_front() : '0;
      sidx <= 3'd0;
    end else if (ser_shift) begin
      sidx <= (sidx != 3'(DW - 1)) ? sidx + 3'd1 : sidx;
    end
  end
  assign ser_data = sreg[sidx];
  assign ser_done = !force_nodone && (sidx == 3'(DW - 1));

  // Expected line frame, straight from the framing rules.
  function automatic frame_t mk_frame(input logic [DW-1:0] d, input bit pe,
                                      input bit pt, input bit ferr);
    frame_t f;
    int n;
    f.bits    = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) f.bits[1 + i] = d[i];
    n = 1 + DW;
    if (pe) begin
      f.bits[n] = (($countones(d) % 2) == 1) ^ pt;
      n = n + 1;
    end
    f.bits[n] = 1'b1;
    f.len = n + 1;
    f.err = ferr ? 1 : 0;
    return f;
  endfunction

  // Monitor: gathers frame bits and pulses, compares on every TX_DONE.
  int          cyc = 0;
  logic [15:0] got_bits = '0;
  int          got_len = 0, got_shift = 0, got_load = 0, got_err = 0;
  frame_t      e;
  logic [15:0] mask;
  initial begin
    forever begin
      @(negedge CLK);
      cyc = cyc + 1;
      if (!RST) begin
        got_bits = '0; got_len = 0; got_shift = 0; got_load = 0; got_err = 0;
      end else begin
        if (TX_DONE) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_tx_done: got a TX_DONE pulse at cycle %0d, required none", cyc);
          end else begin
            e = exp_q.pop_front();
            mask = (16'd1 << e.len) - 16'd1;
            n_checks++;
            if (got_len != e.len || (got_bits & mask) != (e.bits & mask)) begin
              n_errors++;
              $display("FAIL frame_bits: got %0d bits %h, required %0d bits %h (cycle %0d)",
                       got_len, got_bits & mask, e.len, e.bits & mask, cyc);
            end
            n_checks++;
            if (got_shift != DW - 1) begin
              n_errors++;
              $display("FAIL ser_shift_count: got %0d, required %0d", got_shift, DW - 1);
            end
            n_checks++;
            if (got_load != 1) begin
              n_errors++;
              $display("FAIL ser_load_count: got %0d, required 1", got_load);
            end
            n_checks++;
            if (got_err != e.err) begin
              n_errors++;
              $display("FAIL frame_err_count: got %0d, required %0d", got_err, e.err);
            end
          end
          done_time.push_back(cyc);
          got_bits = '0; got_len = 0; got_shift = 0; got_load = 0; got_err = 0;
        end
        if (ser_load)  got_load++;
        if (ser_shift) got_shift++;
        if (FRAME_ERR) got_err++;
        if (TX_tick && BUSY) begin
          if (got_len < 16) got_bits[got_len] = TX_OUT;
          got_len++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Offer one byte when the buffer is free and record what it must produce.
  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt);
    int guard = 0;
    while (!READY && guard < 2000) begin
      step(1);
      guard++;
    end
    chk("send_ready_timeout", READY, 1);
    if (READY) begin
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
      exp_q.push_back(mk_frame(d, pe, pt, force_nodone));
      ser_q.push_back(d);
      step(1);
      DATA_VALID = 1'b0;
      chk("ready_drop_after_accept", READY, 0);
    end
  endtask

  task automatic wait_busy();
    int guard = 0;
    while (!BUSY && guard < 200) begin
      step(1);
      guard++;
    end
    chk("busy_rise", BUSY, 1);
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((exp_q.size() != 0 || BUSY) && c < limit) begin
      step(1);
      c++;
    end
    chk("drain_done", (exp_q.size() == 0 && !BUSY), 1);
  endtask

  initial begin
    int bad;
    int c;
    int sz;
    // Reset state
    RST = 1'b0;
    step(3);
    RST = 1'b1;
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_tx_out", TX_OUT, 1);
    chk("rst_ser_load", ser_load, 0);
    chk("rst_ser_shift", ser_shift, 0);
    chk("rst_tx_done", TX_DONE, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    step(5);

    // Plain frame, no parity
    send(8'hA5, 1'b0, 1'b0);
    drain(400);

    // Even then odd parity on the same byte
    send(8'h03, 1'b1, 1'b0);
    drain(400);
    send(8'h03, 1'b1, 1'b1);
    drain(400);

    // Back-to-back frames; second byte offered while first is in DATA
    send(8'h55, 1'b0, 1'b0);
    wait_busy();
    step(8);
    send(8'h0F, 1'b0, 1'b0);
    bad = 0;
    c = 0;
    while (!TX_DONE && c < 400) begin
      if (READY) bad++;
      step(1);
      c++;
    end
    chk("b2b_ready_held_low", bad, 0);
    chk("b2b_ready_at_second_start", READY, 1);
    drain(400);
    sz = done_time.size();
    chk("b2b_done_count", (sz >= 2), 1);
    if (sz >= 2) chk("b2b_done_spacing", done_time[sz-1] - done_time[sz-2], 40);

    // Serializer never reports done: one FRAME_ERR, frame still completes
    force_nodone = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    drain(400);
    force_nodone = 1'b0;

    // Offers while the buffer is full are dropped
    send(8'h81, 1'b1, 1'b0);
    wait_busy();
    step(8);
    send(8'h01, 1'b1, 1'b0);
    P_DATA = 8'h03; PAR_EN = 1'b0; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    chk("drop_ready_0", READY, 0);
    step(1);
    P_DATA = 8'h0F;
    chk("drop_ready_1", READY, 0);
    step(1);
    P_DATA = 8'h07;
    chk("drop_ready_2", READY, 0);
    step(1);
    DATA_VALID = 1'b0;
    drain(600);

    // Reset in the middle of DATA with a byte buffered
    send(8'h99, 1'b0, 1'b0);
    wait_busy();
    step(8);
    send(8'h42, 1'b1, 1'b0);
    step(3);
    RST = 1'b0;
    exp_q.delete();
    step(1);
    RST = 1'b1;
    chk("midrst_tx_out", TX_OUT, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_ready", READY, 1);
    bad = 0;
    repeat (60) begin
      if (BUSY) bad++;
      step(1);
    end
    chk("midrst_no_restart", bad, 0);

    // Faster baud, back-to-back with mixed parity
    tick_div = 2;
    send(8'hC3, 1'b1, 1'b1);
    send(8'h5A, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    drain(400);

    // Randomized traffic over several baud rates
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) begin
        drain(3000);
        tick_div = $urandom_range(2, 5);
      end
      send(8'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step($urandom_range(0, 12));
    end
    drain(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
